imem_loader: RTL and testbench

Y86-64 instruction encoder and byte-wide instruction memory for the SEQ processor. It accepts decoded instruction fields (icode, ifun, rA, rB, valC) over a valid/ready handshake and serialises them into the Y86 byte encoding, writing one byte per cycle at an auto-incrementing write pointer. It also provides the combinational 10-byte read port that fetch consumes: PC in, `instr[0:79]` out. This lets benches and program loaders build programs from fields rather than hand-placed bytes.

---
 rtl/imem_loader.sv | 180 ++++++++++++++++++
 tb/tb_imem_loader.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: Y86-64 instruction encoder plus byte-wide instruction memory.
// Takes decoded instruction fields over a valid/ready handshake and writes
// their Y86 byte encoding one byte per cycle at an auto-incrementing write
// pointer. Also provides the combinational 10-byte fetch read port.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   in_valid / in_ready       instruction handshake
//   in_icode/in_ifun/in_rA/in_rB/in_valC  instruction fields
//   load_addr_valid/load_addr overwrite the write pointer (IDLE only)
//   wr_ptr                    address where the next instruction goes
//   busy                      an instruction is being emitted
//   done                      one-cycle pulse after the last byte is written
//   err_invalid/err_overflow  one-cycle pulses on rejected instructions
//   rd_pc/rd_instr/rd_error   fetch port: mem[rd_pc..rd_pc+9], mem[rd_pc] in [0:7]
module imem_loader #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_icode,
  input  logic [3:0]  in_ifun,
  input  logic [3:0]  in_rA,
  input  logic [3:0]  in_rB,
  input  logic [63:0] in_valC,
  input  logic        load_addr_valid,
  input  logic [63:0] load_addr,
  output logic [63:0] wr_ptr,
  output logic        busy,
  output logic        done,
  output logic        err_invalid,
  output logic        err_overflow,
  input  logic [63:0] rd_pc,
  output logic [0:79] rd_instr,
  output logic        rd_error
);

  localparam int unsigned AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state, state_next;
  logic [7:0]  mem [MEM_BYTES];

  logic [3:0]  icode_q, ifun_q, ra_q, rb_q;
  logic [63:0] valc_q;
  logic [7:0]  valc_b [8];
  logic [3:0]  len_q;
  logic [3:0]  idx;

  logic [3:0]  in_len;
  logic [64:0] end_addr;
  logic        fits;
  logic        accept;
  logic        last;
  logic [7:0]  emit_byte;
  logic [AW-1:0] wr_addr;

  // Encoded length per icode; 0 marks an invalid icode.
  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:               instr_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB:         instr_len = 4'd2;
      4'h3, 4'h4, 4'h5:               instr_len = 4'd10;
      4'h7, 4'h8:                     instr_len = 4'd9;
      default:                        instr_len = 4'd0;
    endcase
  endfunction

  assign in_len   = instr_len(in_icode);
  // 65-bit sum so a huge loaded pointer cannot wrap into an apparent fit.
  assign end_addr = {1'b0, wr_ptr} + {61'b0, in_len};
  assign fits     = (end_addr <= 65'(MEM_BYTES));

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !load_addr_valid;
        accept   = in_valid && !load_addr_valid;
        if (accept && (in_len != 4'd0) && fits)
          state_next = EMIT;
      end
      EMIT: begin
        busy = 1'b1;
        last = (idx == len_q - 4'd1);
        if (last)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      idx          <= '0;
      done         <= 1'b0;
      err_invalid  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state        <= state_next;
      done         <= 1'b0;
      err_invalid  <= 1'b0;
      err_overflow <= 1'b0;
      if (state == IDLE) begin
        if (load_addr_valid) begin
          wr_ptr <= load_addr;
        end else if (accept) begin
          if (in_len == 4'd0) begin
            err_invalid <= 1'b1;
          end else if (!fits) begin
            err_overflow <= 1'b1;
          end else begin
            idx     <= '0;
            len_q   <= in_len;
            icode_q <= in_icode;
            ifun_q  <= in_ifun;
            ra_q    <= in_rA;
            rb_q    <= in_rB;
            valc_q  <= in_valC;
          end
        end
      end else begin
        if (last) begin
          wr_ptr <= wr_ptr + 64'(len_q);
          done   <= 1'b1;
          idx    <= '0;
        end else begin
          idx <= idx + 4'd1;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 8; i++)
      valc_b[i] = valc_q[8*i +: 8];
  end

  // valC starts at byte 1 for jXX/call (no register byte), byte 2 otherwise.
  always_comb begin
    emit_byte = '0;
    if (idx == 4'd0)
      emit_byte = {icode_q, ifun_q};
    else if (icode_q == 4'h7 || icode_q == 4'h8)
      emit_byte = valc_b[3'(idx - 4'd1)];
    else if (idx == 4'd1)
      emit_byte = {ra_q, rb_q};
    else
      emit_byte = valc_b[3'(idx - 4'd2)];
  end

  // Range was checked at accept, so the low address bits are sufficient.
  assign wr_addr = AW'(wr_ptr) + AW'(idx);

  // Memory is deliberately not reset; rst only blocks further writes.
  always_ff @(posedge clk) begin
    if (!rst && state == EMIT)
      mem[wr_addr] <= emit_byte;
  end

  always_comb begin
    rd_instr = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (({1'b0, rd_pc} + 65'(i)) < 65'(MEM_BYTES))
        rd_instr[8*i +: 8] = mem[AW'(rd_pc + 64'(i))];
    end
  end

  assign rd_error = (rd_pc >= 64'(MEM_BYTES));

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected memory writes go to a
// scoreboard queue at accept time and are compared through the read port
// once the instruction has completed.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_icode, in_ifun, in_rA, in_rB;
  logic [63:0] in_valC;
  logic        load_addr_valid;
  logic [63:0] load_addr;
  logic [63:0] wr_ptr;
  logic        busy, done, err_invalid, err_overflow;
  logic [63:0] rd_pc;
  logic [0:79] rd_instr;
  logic        rd_error;

  always #5 clk = ~clk;

  imem_loader #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_icode(in_icode), .in_ifun(in_ifun), .in_rA(in_rA), .in_rB(in_rB),
    .in_valC(in_valC),
    .load_addr_valid(load_addr_valid), .load_addr(load_addr),
    .wr_ptr(wr_ptr), .busy(busy), .done(done),
    .err_invalid(err_invalid), .err_overflow(err_overflow),
    .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_error(rd_error)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t sb[$];
  logic [63:0] exp_ptr;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned len_of(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 1;
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h3, 4'h4, 4'h5:       return 10;
      4'h7, 4'h8:             return 9;
      default:                return 0;
    endcase
  endfunction

  task automatic push_expected(input logic [63:0] base, input logic [3:0] ic,
                               input logic [3:0] ifn, input logic [3:0] ra,
                               input logic [3:0] rb, input logic [63:0] vc);
    logic [7:0] b [10];
    int unsigned n;
    wr_t e;
    n = len_of(ic);
    for (int i = 0; i < 10; i++) b[i] = 8'h00;
    b[0] = {ic, ifn};
    case (ic)
      4'h3, 4'h4, 4'h5: begin
        b[1] = {ra, rb};
        for (int k = 0; k < 8; k++) b[2+k] = vc[8*k +: 8];
      end
      4'h7, 4'h8: for (int k = 0; k < 8; k++) b[1+k] = vc[8*k +: 8];
      4'h2, 4'h6, 4'hA, 4'hB: b[1] = {ra, rb};
      default: ;
    endcase
    for (int unsigned i = 0; i < n; i++) begin
      e.addr = base + 64'(i);
      e.data = b[i];
      sb.push_back(e);
    end
  endtask

  task automatic set_fields(input logic [3:0] ic, input logic [3:0] ifn,
                            input logic [3:0] ra, input logic [3:0] rb,
                            input logic [63:0] vc);
    in_icode = ic; in_ifun = ifn; in_rA = ra; in_rB = rb; in_valC = vc;
  endtask

  task automatic drain;
    wr_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_pc = e.addr;
      #1;
      checks++;
      if (rd_instr[0:7] !== e.data) begin
        errors++;
        $display("FAIL mem_byte[%0d]: got %h expected %h", e.addr, rd_instr[0:7], e.data);
      end
    end
    tick;
  endtask

  task automatic load(input logic [63:0] a);
    load_addr_valid = 1'b1;
    load_addr = a;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL load_ready: got %b expected 0", in_ready);
    end
    tick;
    load_addr_valid = 1'b0;
    exp_ptr = a;
    checks++;
    if (wr_ptr !== a) begin
      errors++; $display("FAIL load_ptr: got %0d expected %0d", wr_ptr, a);
    end
  endtask

  // Issue one valid instruction from IDLE and check its full timing.
  task automatic run_instr(input logic [3:0] ic, input logic [3:0] ifn,
                           input logic [3:0] ra, input logic [3:0] rb,
                           input logic [63:0] vc);
    int unsigned n;
    int c, busy_cnt, rdy_low;
    n = len_of(ic);
    set_fields(ic, ifn, ra, rb, vc);
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL pre_accept_ready: got %b expected 1", in_ready);
    end
    tick;
    in_valid = 1'b0;
    push_expected(exp_ptr, ic, ifn, ra, rb, vc);
    c = 0; busy_cnt = 0; rdy_low = 0;
    while (done !== 1'b1 && c < int'(n) + 4) begin
      if (busy === 1'b1) busy_cnt++;
      if (in_ready !== 1'b1) rdy_low++;
      tick;
      c++;
    end
    exp_ptr = exp_ptr + 64'(n);
    checks++;
    if (done !== 1'b1 || c != int'(n)) begin
      errors++; $display("FAIL done_latency: got %0d cycles (done=%b) expected %0d", c, done, n);
    end
    checks++;
    if (busy_cnt != int'(n) || rdy_low != int'(n)) begin
      errors++; $display("FAIL busy_cycles: got busy=%0d ready_low=%0d expected %0d", busy_cnt, rdy_low, n);
    end
    checks++;
    if (wr_ptr !== exp_ptr) begin
      errors++; $display("FAIL wr_ptr_after: got %0d expected %0d", wr_ptr, exp_ptr);
    end
    tick;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL done_pulse_width: got %b expected 0", done);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        err_invalid !== 1'b0 || err_overflow !== 1'b0 || wr_ptr !== 64'd0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b busy=%b done=%b ei=%b eo=%b ptr=%0d expected 1 0 0 0 0 0",
               in_ready, busy, done, err_invalid, err_overflow, wr_ptr);
    end
    rst = 1'b0;
    exp_ptr = '0;
  endtask

  task automatic test_nop;
    run_instr(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
    rd_pc = 64'd0;
    #1;
    checks++;
    if (rd_instr[0:7] !== 8'h10) begin
      errors++; $display("FAIL nop_read: got %h expected 10", rd_instr[0:7]);
    end
    drain;
  endtask

  task automatic test_irmovq;
    load(64'd3);
    run_instr(4'h3, 4'h0, 4'hF, 4'h2, 64'd145);
    rd_pc = 64'd3;
    #1;
    checks++;
    if (rd_instr !== 80'h30F29100000000000000) begin
      errors++; $display("FAIL irmovq_read: got %h expected 30f29100000000000000", rd_instr);
    end
    drain;
  endtask

  task automatic test_back_to_back;
    int c;
    load(64'd33);
    set_fields(4'h2, 4'h2, 4'hB, 4'hC, 64'd0);
    in_valid = 1'b1;
    #1;
    tick;
    push_expected(exp_ptr, 4'h2, 4'h2, 4'hB, 4'hC, 64'd0);
    exp_ptr = exp_ptr + 64'd2;
    set_fields(4'h7, 4'h3, 4'hF, 4'hF, 64'd50);
    c = 0;
    while (in_ready !== 1'b1 && c < 20) begin
      tick;
      c++;
    end
    checks++;
    if (c + 1 != 3 || done !== 1'b1) begin
      errors++; $display("FAIL b2b_gap: got %0d cycles (done=%b) expected 3", c + 1, done);
    end
    tick;
    in_valid = 1'b0;
    push_expected(exp_ptr, 4'h7, 4'h3, 4'hF, 4'hF, 64'd50);
    exp_ptr = exp_ptr + 64'd9;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL b2b_second_busy: got %b expected 1", busy);
    end
    c = 0;
    while (done !== 1'b1 && c < 20) begin
      tick;
      c++;
    end
    checks++;
    if (done !== 1'b1 || wr_ptr !== 64'd44) begin
      errors++; $display("FAIL b2b_ptr: got %0d (done=%b) expected 44", wr_ptr, done);
    end
    tick;
    drain;
  endtask

  task automatic test_invalid;
    set_fields(4'hC, 4'h0, 4'h0, 4'h0, 64'd0);
    in_valid = 1'b1;
    #1;
    tick;
    in_valid = 1'b0;
    checks++;
    if (err_invalid !== 1'b1 || err_overflow !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL invalid_pulse: got ei=%b eo=%b busy=%b ready=%b expected 1 0 0 1",
               err_invalid, err_overflow, busy, in_ready);
    end
    tick;
    checks++;
    if (err_invalid !== 1'b0 || wr_ptr !== exp_ptr) begin
      errors++; $display("FAIL invalid_after: got ei=%b ptr=%0d expected 0 %0d", err_invalid, wr_ptr, exp_ptr);
    end
  endtask

  task automatic test_overflow;
    load(64'd1020);
    for (int i = 0; i < 4; i++) run_instr(4'h0, 4'h0, 4'h0, 4'h0, 64'd0);
    drain;
    load(64'd1020);
    set_fields(4'h3, 4'h0, 4'hF, 4'h2, 64'd145);
    in_valid = 1'b1;
    #1;
    tick;
    in_valid = 1'b0;
    checks++;
    if (err_overflow !== 1'b1 || err_invalid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL overflow_pulse: got eo=%b ei=%b busy=%b expected 1 0 0",
                         err_overflow, err_invalid, busy);
    end
    tick;
    checks++;
    if (err_overflow !== 1'b0 || busy !== 1'b0 || wr_ptr !== 64'd1020) begin
      errors++; $display("FAIL overflow_after: got eo=%b busy=%b ptr=%0d expected 0 0 1020",
                         err_overflow, busy, wr_ptr);
    end
    rd_pc = 64'd1020;
    #1;
    checks++;
    if (rd_instr !== 80'h0) begin
      errors++; $display("FAIL overflow_nowrite: got %h expected 0", rd_instr);
    end
    tick;
    load(64'd1023);
    run_instr(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
    rd_pc = 64'd1020;
    #1;
    checks++;
    if (rd_instr !== 80'h00000010000000000000) begin
      errors++; $display("FAIL last_byte_read: got %h expected 00000010000000000000", rd_instr);
    end
    drain;
  endtask

  task automatic test_load_priority;
    load_addr_valid = 1'b1;
    load_addr = 64'd200;
    set_fields(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL prio_ready: got %b expected 0", in_ready);
    end
    tick;
    load_addr_valid = 1'b0;
    exp_ptr = 64'd200;
    checks++;
    if (busy !== 1'b0 || wr_ptr !== 64'd200) begin
      errors++; $display("FAIL prio_load: got busy=%b ptr=%0d expected 0 200", busy, wr_ptr);
    end
    run_instr(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
    drain;
  endtask

  task automatic test_reset_abort;
    load(64'd100);
    for (int i = 0; i < 10; i++) run_instr(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
    drain;
    load(64'd100);
    set_fields(4'h3, 4'h0, 4'hF, 4'h2, 64'd145);
    in_valid = 1'b1;
    #1;
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_ptr = '0;
    checks++;
    if (busy !== 1'b0 || wr_ptr !== 64'd0 || done !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL abort_state: got busy=%b ptr=%0d done=%b ready=%b expected 0 0 0 1",
                         busy, wr_ptr, done, in_ready);
    end
    rd_pc = 64'd100;
    #1;
    checks++;
    if (rd_instr !== 80'h30F29100101010101010) begin
      errors++; $display("FAIL abort_mem: got %h expected 30f29100101010101010", rd_instr);
    end
    tick;
  endtask

  task automatic test_read_oob;
    rd_pc = 64'd1024;
    #1;
    checks++;
    if (rd_error !== 1'b1 || rd_instr !== 80'h0) begin
      errors++; $display("FAIL oob_1024: got err=%b data=%h expected 1 0", rd_error, rd_instr);
    end
    rd_pc = 64'd1023;
    #1;
    checks++;
    if (rd_error !== 1'b0 || rd_instr !== {8'h10, 72'h0}) begin
      errors++; $display("FAIL oob_1023: got err=%b data=%h expected 0 10000000000000000000", rd_error, rd_instr);
    end
    rd_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    checks++;
    if (rd_error !== 1'b1 || rd_instr !== 80'h0) begin
      errors++; $display("FAIL oob_max: got err=%b data=%h expected 1 0", rd_error, rd_instr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    load_addr_valid = 1'b0;
    load_addr = '0;
    rd_pc = '0;
    exp_ptr = '0;
    set_fields(4'h0, 4'h0, 4'h0, 4'h0, 64'd0);
    test_reset;
    test_nop;
    test_irmovq;
    test_back_to_back;
    test_invalid;
    test_overflow;
    test_load_priority;
    test_reset_abort;
    test_read_oob;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
